// File: rtl/lane_stripe_raster.sv
// Lane-stripe raster: per-frame geometry snapshot, blanking-time lane-mask scanner, 2-stage pixel hit pipeline.
// Optional macro LANE_STRIPE_ID_EN adds stripe_lane (lowest hitting lane, 3'd7 when none).
module lane_stripe_raster #(
   parameter int NUM_STRIPES = 60,
   parameter int NUM_LANES   = 6,
   parameter int CW          = 11
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_start,
   input  logic [NUM_STRIPES-1:0][CW-1:0] StripeX,
   input  logic [NUM_STRIPES-1:0][CW-1:0] StripeY,
   input  logic [CW-1:0]                  StripeW,
   input  logic [CW-1:0]                  StripeH,
   input  logic                           line_start,
   input  logic [CW-1:0]                  LineY,
   input  logic                           pixel_en,
   input  logic [CW-1:0]                  DrawX,
   output logic                           stripe_on,
   output logic                           pix_valid,
   output logic                           scan_busy,
   output logic                           scan_overrun
`ifdef LANE_STRIPE_ID_EN
   ,
   output logic [2:0]                     stripe_lane
`endif
);
   localparam int PER_LANE = NUM_STRIPES / NUM_LANES;
   localparam int IW       = $clog2(NUM_STRIPES);
   localparam int LW       = $clog2(NUM_LANES);
   localparam int SW       = $clog2(PER_LANE);
   localparam int STAGES   = 2;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   logic [NUM_STRIPES-1:0][CW-1:0] shx_q, shx_d, shy_q, shy_d;
   logic [CW-1:0]                  shw_q, shw_d, shh_q, shh_d;
   state_t                         state_q, state_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [LW-1:0]                  lane_q, lane_d;
   logic [SW-1:0]                  sub_q, sub_d;
   logic [CW-1:0]                  line_q, line_d;
   logic [NUM_LANES-1:0]           pend_q, pend_d, mask_q, mask_d;
   logic                           ovr_q, ovr_d;
   logic [NUM_LANES-1:0]           inlane_q, inlane_d;
   logic [STAGES:1]                vld_pipe_q, vld_pipe_d;
   logic                           stripe_on_q, stripe_on_d;
   logic                           busy, hit;

   assign busy = (state_q != IDLE);
   // CW+1-bit sum so a stripe near the bottom edge never wraps to row 0
   assign hit  = ({1'b0, line_q} >= {1'b0, shy_q[idx_q]}) &&
                 ({1'b0, line_q} <  ({1'b0, shy_q[idx_q]} + {1'b0, shh_q}));

   always_comb begin
      shx_d = shx_q;
      shy_d = shy_q;
      shw_d = shw_q;
      shh_d = shh_q;
      if (frame_start) begin
         shx_d = StripeX;
         shy_d = StripeY;
         shw_d = StripeW;
         shh_d = StripeH;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      sub_d   = sub_q;
      line_d  = line_q;
      pend_d  = pend_q;
      mask_d  = mask_q;
      ovr_d   = ovr_q;
      case (state_q)
         SCAN: begin
            if (hit) pend_d[lane_q] = 1'b1;
            if (idx_q == IW'(NUM_STRIPES-1)) begin
               state_d = COMMIT;
            end else begin
               idx_d = idx_q + IW'(1);
               if (sub_q == SW'(PER_LANE-1)) begin
                  sub_d  = '0;
                  lane_d = lane_q + LW'(1);
               end else begin
                  sub_d = sub_q + SW'(1);
               end
            end
         end
         COMMIT: begin
            mask_d  = pend_q;
            state_d = IDLE;
         end
         default: ;
      endcase
      if (frame_start && busy) begin
         state_d = IDLE;
         pend_d  = '0;
         mask_d  = '0;
      end
      // a new request always wins; an interrupted scan never commits
      if (line_start) begin
         if (busy) ovr_d = 1'b1;
         line_d  = LineY;
         pend_d  = '0;
         idx_d   = '0;
         lane_d  = '0;
         sub_d   = '0;
         state_d = SCAN;
         mask_d  = (frame_start && busy) ? '0 : mask_q;
      end
      if (pixel_en && busy) ovr_d = 1'b1;
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign inlane_d[l] = ({1'b0, DrawX} >= {1'b0, shx_q[l*PER_LANE]}) &&
                           ({1'b0, DrawX} <  ({1'b0, shx_q[l*PER_LANE]} + {1'b0, shw_q}));
   end

   always_comb begin
      vld_pipe_d  = {vld_pipe_q[STAGES-1:1], pixel_en};
      stripe_on_d = vld_pipe_q[1] & (|(inlane_q & mask_q));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         shx_q       <= '0;
         shy_q       <= '0;
         shw_q       <= '0;
         shh_q       <= '0;
         state_q     <= IDLE;
         idx_q       <= '0;
         lane_q      <= '0;
         sub_q       <= '0;
         line_q      <= '0;
         pend_q      <= '0;
         mask_q      <= '0;
         ovr_q       <= 1'b0;
         inlane_q    <= '0;
         vld_pipe_q  <= '0;
         stripe_on_q <= 1'b0;
      end else begin
         shx_q       <= shx_d;
         shy_q       <= shy_d;
         shw_q       <= shw_d;
         shh_q       <= shh_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         lane_q      <= lane_d;
         sub_q       <= sub_d;
         line_q      <= line_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         ovr_q       <= ovr_d;
         inlane_q    <= inlane_d;
         vld_pipe_q  <= vld_pipe_d;
         stripe_on_q <= stripe_on_d;
      end
   end

   assign stripe_on    = stripe_on_q;
   assign pix_valid    = vld_pipe_q[STAGES];
   assign scan_busy    = busy;
   assign scan_overrun = ovr_q;

`ifdef LANE_STRIPE_ID_EN
   logic [2:0] lane_id_q, lane_id_d;

   always_comb begin
      lane_id_d = 3'd7;
      for (int l = NUM_LANES-1; l >= 0; l--)
         if (vld_pipe_q[1] && inlane_q[l] && mask_q[l]) lane_id_d = 3'(l);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) lane_id_q <= 3'd7;
      else       lane_id_q <= lane_id_d;
   end

   assign stripe_lane = lane_id_q;
`endif
endmodule

// File: tb/tb_lane_stripe_raster.sv
// Directed bench for lane_stripe_raster: snapshot, scan timing/mask, pixel hits, overrun, abort, lane id.
module tb_lane_stripe_raster;
   localparam int NS = 60;
   localparam int CW = 11;

   logic                   Clk = 1'b0;
   logic                   Reset = 1'b0;
   logic                   frame_start = 1'b0, line_start = 1'b0, pixel_en = 1'b0;
   logic [NS-1:0][CW-1:0]  StripeX = '0, StripeY = '0;
   logic [CW-1:0]          StripeW = '0, StripeH = '0, LineY = '0, DrawX = '0;
   logic                   stripe_on, pix_valid, scan_busy, scan_overrun;
`ifdef LANE_STRIPE_ID_EN
   logic [2:0]             stripe_lane;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int lane_x [6] = '{0, 125, 253, 381, 509, 637};

   always #5 Clk = ~Clk;

   lane_stripe_raster dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .StripeX(StripeX), .StripeY(StripeY), .StripeW(StripeW), .StripeH(StripeH),
      .line_start(line_start), .LineY(LineY), .pixel_en(pixel_en), .DrawX(DrawX),
      .stripe_on(stripe_on), .pix_valid(pix_valid), .scan_busy(scan_busy),
      .scan_overrun(scan_overrun)
`ifdef LANE_STRIPE_ID_EN
      , .stripe_lane(stripe_lane)
`endif
   );

   task automatic set_geom(input int yoff, input int w, input int h);
      for (int i = 0; i < NS; i++) begin
         StripeX[i] = CW'(lane_x[i/10]);
         StripeY[i] = CW'((i % 10) * 48 + yoff);
      end
      StripeW = CW'(w);
      StripeH = CW'(h);
   endtask

   // snapshot, then scramble inputs so any later copy would be visible
   task automatic load(input int yoff, input int w, input int h);
      @(negedge Clk);
      set_geom(yoff, w, h);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      for (int i = 0; i < NS; i++) begin
         StripeX[i] = 11'd2000;
         StripeY[i] = 11'd2000;
      end
      StripeW = '0;
      StripeH = '0;
   endtask

   task automatic run_scan(input int y, output int cnt);
      @(negedge Clk);
      line_start = 1'b1;
      LineY = CW'(y);
      @(negedge Clk);
      line_start = 1'b0;
      cnt = 0;
      while (scan_busy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge Clk);
      end
   endtask

   task automatic pix(input int x, output logic on, output logic vld, output logic [2:0] id);
      @(negedge Clk);
      pixel_en = 1'b1;
      DrawX = CW'(x);
      @(negedge Clk);
      pixel_en = 1'b0;
      @(negedge Clk);
      on  = stripe_on;
      vld = pix_valid;
`ifdef LANE_STRIPE_ID_EN
      id = stripe_lane;
`else
      id = 3'd7;
`endif
   endtask

   task automatic test_reset();
      logic on, vld;
      logic [2:0] id;
      Reset = 1'b1;
      #12;
      n_cmp++;
      if ({scan_busy, stripe_on, pix_valid, scan_overrun} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_outs: got %b want 0000", {scan_busy, stripe_on, pix_valid, scan_overrun});
      end
`ifdef LANE_STRIPE_ID_EN
      n_cmp++;
      if (stripe_lane !== 3'd7) begin
         n_bad++;
         $display("FAIL reset_lane: got %0d want 7", stripe_lane);
      end
`endif
      @(negedge Clk);
      Reset = 1'b0;
      load(0, 6, 38);
      @(negedge Clk); line_start = 1'b1; LineY = 11'd10;
      @(negedge Clk); line_start = 1'b0;
      repeat (5) @(negedge Clk);
      line_start = 1'b1;
      @(negedge Clk); line_start = 1'b0;
      repeat (3) @(negedge Clk);
      n_cmp++;
      if ({scan_busy, scan_overrun} !== 2'b11) begin
         n_bad++;
         $display("FAIL midscan_busy_ovr: got %b want 11", {scan_busy, scan_overrun});
      end
      #2 Reset = 1'b1;
      #1;
      n_cmp++;
      if ({scan_busy, stripe_on, pix_valid, scan_overrun} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_midscan: got %b want 0000", {scan_busy, stripe_on, pix_valid, scan_overrun});
      end
      @(negedge Clk);
      Reset = 1'b0;
      load(0, 6, 38);
      pix(0, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b10) begin
         n_bad++;
         $display("FAIL reset_mask_cleared: got %b want 10", {vld, on});
      end
   endtask

   task automatic test_scan_hit();
      int cnt;
      logic on, vld;
      logic [2:0] id;
      int xs [11] = '{127, 131, 0, 5, 6, 124, 253, 381, 509, 642, 643};
      logic exp [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      load(0, 6, 38);
      run_scan(10, cnt);
      n_cmp++;
      if (cnt != 61) begin
         n_bad++;
         $display("FAIL scan_cycles_y10: got %0d want 61", cnt);
      end
      for (int k = 0; k < 11; k++) begin
         pix(xs[k], on, vld, id);
         n_cmp++;
         if ({vld, on} !== {1'b1, exp[k]}) begin
            n_bad++;
            $display("FAIL hit_x%0d: got vld/on %b want %b", xs[k], {vld, on}, {1'b1, exp[k]});
         end
      end
   endtask

   task automatic test_gap();
      int cnt, hits, valids;
      logic on, vld;
      logic [2:0] id;
      run_scan(40, cnt);
      n_cmp++;
      if (cnt != 61) begin
         n_bad++;
         $display("FAIL scan_cycles_y40: got %0d want 61", cnt);
      end
      hits = 0;
      valids = 0;
      for (int x = 0; x < 642; x++) begin
         @(negedge Clk);
         if (x >= 2) begin
            if (stripe_on !== 1'b0) hits++;
            if (pix_valid === 1'b1) valids++;
         end
         pixel_en = (x < 640);
         DrawX = (x < 640) ? CW'(x) : '0;
      end
      @(negedge Clk);
      pixel_en = 1'b0;
      n_cmp++;
      if (hits != 0 || valids != 640) begin
         n_bad++;
         $display("FAIL gap_sweep: got hits=%0d valids=%0d want 0 640", hits, valids);
      end
      run_scan(48, cnt);
      pix(0, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b11) begin
         n_bad++;
         $display("FAIL y48_x0: got %b want 11", {vld, on});
      end
      pix(637, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b11) begin
         n_bad++;
         $display("FAIL y48_x637: got %b want 11", {vld, on});
      end
   endtask

   task automatic test_overrun();
      int cnt;
      logic on, vld;
      logic [2:0] id;
      run_scan(40, cnt);
      n_cmp++;
      if (scan_overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_before: got %b want 0", scan_overrun);
      end
      @(negedge Clk); line_start = 1'b1; LineY = 11'd10;
      @(negedge Clk); line_start = 1'b0;
      pix(127, on, vld, id);
      n_cmp++;
      if ({vld, on, scan_overrun} !== 3'b101) begin
         n_bad++;
         $display("FAIL pix_during_scan: got vld/on/ovr %b want 101", {vld, on, scan_overrun});
      end
      run_scan(10, cnt);
      n_cmp++;
      if (cnt != 61) begin
         n_bad++;
         $display("FAIL restart_cycles: got %0d want 61", cnt);
      end
      pix(127, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b11) begin
         n_bad++;
         $display("FAIL restart_mask: got %b want 11", {vld, on});
      end
   endtask

   task automatic test_frame_abort();
      int cnt;
      logic on, vld;
      logic [2:0] id;
      @(negedge Clk); line_start = 1'b1; LineY = 11'd10;
      @(negedge Clk); line_start = 1'b0;
      repeat (30) @(negedge Clk);
      n_cmp++;
      if (scan_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_pre_busy: got %b want 1", scan_busy);
      end
      set_geom(100, 6, 38);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      n_cmp++;
      if (scan_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_busy: got %b want 0", scan_busy);
      end
      pix(0, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b10) begin
         n_bad++;
         $display("FAIL abort_mask: got %b want 10", {vld, on});
      end
      run_scan(135, cnt);
      pix(0, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b11) begin
         n_bad++;
         $display("FAIL abort_new_shadow: got %b want 11", {vld, on});
      end
   endtask

   task automatic test_same_edge();
      int cnt;
      logic on, vld;
      logic [2:0] id;
      @(negedge Clk);
      set_geom(0, 6, 38);
      frame_start = 1'b1;
      line_start = 1'b1;
      LineY = 11'd135;
      @(negedge Clk);
      frame_start = 1'b0;
      line_start = 1'b0;
      cnt = 0;
      while (scan_busy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge Clk);
      end
      n_cmp++;
      if (cnt != 61) begin
         n_bad++;
         $display("FAIL same_edge_cycles: got %0d want 61", cnt);
      end
      pix(0, on, vld, id);
      n_cmp++;
      if ({vld, on} !== 2'b10) begin
         n_bad++;
         $display("FAIL same_edge_new_y: got %b want 10", {vld, on});
      end
   endtask

`ifdef LANE_STRIPE_ID_EN
   task automatic test_lane_id();
      int cnt;
      logic on, vld;
      logic [2:0] id;
      int xs [3] = '{150, 300, 1000};
      logic [3:0] exp [3] = '{4'b1_000, 4'b1_001, 4'b0_111};
      load(0, 200, 38);
      run_scan(10, cnt);
      for (int k = 0; k < 3; k++) begin
         pix(xs[k], on, vld, id);
         n_cmp++;
         if ({on, id} !== exp[k]) begin
            n_bad++;
            $display("FAIL lane_id_x%0d: got on/id %b want %b", xs[k], {on, id}, exp[k]);
         end
      end
      run_scan(40, cnt);
      pix(150, on, vld, id);
      n_cmp++;
      if ({on, id} !== 4'b0_111) begin
         n_bad++;
         $display("FAIL lane_id_nomask: got on/id %b want 0111", {on, id});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan_hit();
      test_gap();
      test_overrun();
      test_frame_abort();
      test_same_edge();
`ifdef LANE_STRIPE_ID_EN
      test_lane_id();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lane_stripe_raster.md
Name: lane_stripe_raster

Overview:
- Consumer end of the lane-stripe interface. Takes the 60 stripe positions and the stripe size produced by the stripe generator, plus the VGA pixel stream.
- Outputs a per-pixel "stripe here" flag for the color mapper.
- Snapshots stripe geometry once per frame, so mid-frame motion causes no tearing.
- A sequential scanner runs during horizontal blanking and builds a per-line lane mask; a 2-stage pixel pipeline applies it.

Parameters:
- NUM_STRIPES, 60, total stripe entries; index i belongs to lane i/10.
- NUM_LANES, 6, lanes; lane X is taken from entry lane*10.
- CW, 11, coordinate width in bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-Clk pulse at vertical blank; triggers the snapshot.
- StripeX  in  CW x NUM_STRIPES  stripe left X.
- StripeY  in  CW x NUM_STRIPES  stripe top Y.
- StripeW  in  CW  stripe width.
- StripeH  in  CW  stripe height.
- line_start  in  1  one-Clk pulse requesting a scan for the line LineY.
- LineY  in  CW  row to scan; sampled when line_start is high.
- pixel_en  in  1  pixel strobe for DrawX.
- DrawX  in  CW  current pixel column.
- stripe_on  out  1  pixel is on a stripe; valid when pix_valid is high.
- pix_valid  out  1  pixel_en delayed by 2 cycles.
- scan_busy  out  1  scanner is active.
- scan_overrun  out  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset (async, active-high):
  - all shadow X/Y/W/H regs = 0; lane mask = 0; pending mask = 0.
  - FSM = IDLE; index = 0.
  - stripe_on = 0, pix_valid = 0, scan_busy = 0, scan_overrun = 0.
- Snapshot:
  - On frame_start, all 60 X/Y values plus W and H are copied to shadow regs on the same edge.
  - Shadow regs do not change at any other time.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE, line_start: latch LineY, clear pending mask, index = 0, go to SCAN.
  - SCAN: one stripe per Clk.
    - hit = (LineY >= Y[i]) && (LineY < Y[i] + H). The sum is computed at CW+1 bits, so there is no wrap.
    - On hit, set pending bit i/10.
    - At index 59, go to COMMIT.
  - COMMIT: active lane mask = pending mask; go to IDLE.
  - Timing: line_start to mask update is 61 Clk. scan_busy is high in SCAN and COMMIT.
- Simultaneous and boundary events:
  - line_start while SCAN/COMMIT: set scan_overrun; restart the scan from index 0 with the new LineY. The active mask keeps its old value.
  - frame_start while SCAN/COMMIT: abort to IDLE; active mask = 0; pending mask discarded.
  - frame_start and line_start on the same edge: snapshot is taken; scan starts (SCAN entered next cycle) and uses the new shadow values.
  - pixel_en while scan_busy: set scan_overrun; the pixel uses the current active mask.
- Pixel pipeline:
  - Stage 1 (registered): for each lane L, inlane[L] = (DrawX >= X[L*10]) && (DrawX < X[L*10] + W), computed at CW+1 bits.
  - Stage 2 (registered): stripe_on = |(inlane & active_mask).
  - pix_valid follows pixel_en with 2 Clk latency. When pix_valid is 0, stripe_on is 0.
  - Pipeline is fully pipelined: one pixel per Clk, no stalls.
  - Mask used: the active mask as of stage 2.
- Edge cases:
  - W = 0 or H = 0 produces no hits.
  - Coordinates are unsigned.
  - A stripe with Y near 2^CW-1 does not wrap to the top.

Optional Feature:
- Macro: LANE_STRIPE_ID_EN.
- Defined: adds output stripe_lane [2:0] = lowest lane index L with inlane[L] & mask[L]; 3'd7 when no lane hits. Same 2-cycle latency and valid as stripe_on. Reset value 3'd7.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset asserted mid-scan (scan_busy=1) -> same cycle: scan_busy=0, stripe_on=0, scan_overrun=0, mask=0.
2. Snapshot lanes X={0,125,253,381,509,637}, Y[i]=(i%10)*48, W=6, H=38; line_start LineY=10 -> scan_busy high 61 Clk, mask=6'b111111. Then DrawX=127 -> stripe_on=1 two Clk later; DrawX=131 -> stripe_on=0; DrawX=0 -> stripe_on=1.
3. Same snapshot, LineY=40 (gap 38..47) -> mask=0, stripe_on=0 for DrawX 0..639. LineY=48 -> mask=6'b111111.
4. pixel_en with DrawX=127 during a scan after a LineY=40 commit -> scan_overrun=1, stripe_on=0 (old mask). A second line_start mid-scan also sets the flag and restarts (61 Clk more).
5. frame_start at scan index 30 -> next Clk scan_busy=0, mask=0; new shadow values are visible on the next scan.
6. LANE_STRIPE_ID_EN defined, W=200, X lane0=0, lane1=125, DrawX=150 -> stripe_lane=0; DrawX=300 -> stripe_lane=1; mask=0 -> stripe_lane=7.
